// File: rtl/lsu_byte_seq.sv
// lsu_byte_seq: sequences byte/half/word loads and stores onto a byte-wide RAM.
// Little-endian, one RAM byte per cycle, sign/zero extension of load data.
module lsu_byte_seq #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_signed,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [31:0]           o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wdata,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } state_t;

    state_t                state;
    logic [1:0]            k;
    logic                  we;
    logic [1:0]            size;
    logic                  sgn;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic [31:0]           ldata;
    logic [31:0]           rdata;
    logic                  err;

    logic                  req_err;
    logic [1:0]            last_k;
    logic [31:0]           cap;
    logic [31:0]           ext;
    logic                  xfer;
    logic                  ram_we;

    always_comb begin
        req_err = 1'b0;
        unique case (i_req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = i_req_addr[0];
            2'b10:   req_err = |i_req_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    // Final byte index is N-1: 0, 1 or 3 for byte, half, word.
    assign last_k = {size[1], size[1] | size[0]};

    always_comb begin
        cap = ldata;
        cap[{k, 3'b000} +: 8] = i_ram_rdata;
    end

    always_comb begin
        ext = cap;
        unique case (size)
            2'b00:   ext = {{24{sgn & cap[7]}}, cap[7:0]};
            2'b01:   ext = {{16{sgn & cap[15]}}, cap[15:0]};
            default: ext = cap;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            k     <= 2'd0;
            we    <= 1'b0;
            size  <= 2'd0;
            sgn   <= 1'b0;
            addr  <= '0;
            wdata <= 32'd0;
            ldata <= 32'd0;
            rdata <= 32'd0;
            err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        we    <= i_req_we;
                        size  <= i_req_size;
                        sgn   <= i_req_signed;
                        addr  <= i_req_addr;
                        wdata <= i_req_wdata;
                        ldata <= 32'd0;
                        k     <= 2'd0;
                        rdata <= 32'd0;
                        err   <= req_err;
                        state <= req_err ? RESP : XFER;
                    end
                end
                XFER: begin
                    if (!we) begin
                        ldata <= cap;
                    end
                    if (k == last_k) begin
                        k     <= 2'd0;
                        rdata <= we ? 32'd0 : ext;
                        state <= RESP;
                    end else begin
                        k <= k + 2'd1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset gates the strobes so an aborted store writes nothing more.
    assign xfer        = (state == XFER);
    assign ram_we      = i_rst_n & xfer & we;
    assign o_req_ready = i_rst_n & (state == IDLE);
    assign o_rsp_valid = i_rst_n & (state == RESP);
    assign o_ram_we    = ram_we;
    assign o_ram_addr  = xfer ? addr + ADDR_WIDTH'(k) : addr;
    assign o_ram_wdata = ram_we ? wdata[{k, 3'b000} +: 8] : '0;
    assign o_rsp_rdata = rdata;
    assign o_rsp_err   = err;

endmodule

// File: tb/tb_lsu_byte_seq.sv
// tb_lsu_byte_seq: directed vectors with a response scoreboard
// and a byte-wide RAM model.
module tb_lsu_byte_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [0:65535];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   passed = 0;
    int   cyc = 0;
    int   we_cnt = 0;
    int   hs_edge = 0;
    int   last_acc = 0;
    bit   seen = 0;

    lsu_byte_seq #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_size   (req_size),
        .i_req_signed (req_signed),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_rdata  (rsp_rdata),
        .o_rsp_err    (rsp_err),
        .o_ram_we     (ram_we),
        .o_ram_addr   (ram_addr),
        .o_ram_wdata  (ram_wdata),
        .i_ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    always @(negedge clk) if (ram_we) we_cnt++;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard monitor: latency on first valid cycle, data on handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (q.size() == 0) begin
                check(1'b0, "unexpected_rsp", rsp_rdata, 32'h0);
            end else begin
                if (!seen) begin
                    check(cyc - q[0].acc + 1 == q[0].lat, "latency",
                          cyc - q[0].acc + 1, q[0].lat);
                    seen = 1;
                end
                if (rsp_ready) begin
                    check(rsp_rdata == q[0].rdata, "rsp_rdata",
                          rsp_rdata, q[0].rdata);
                    check(rsp_err == q[0].err, "rsp_err",
                          32'(rsp_err), 32'(q[0].err));
                    void'(q.pop_front());
                    seen = 0;
                    hs_edge = cyc + 1;
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size,
                         input logic sgn, input logic [15:0] addr,
                         input logic [31:0] wd, input bit expect_rsp,
                         input logic [31:0] erd, input logic eerr,
                         input int elat);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        req_we = we;
        req_size = size;
        req_signed = sgn;
        req_addr = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(req_ready, "accept_timeout", 32'(req_ready), 32'h1);
        if (req_ready) begin
            last_acc = cyc + 1;
            if (expect_rsp) q.push_back('{erd, eerr, elat, cyc + 1});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(q.size() == 0, "drain_timeout", q.size(), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h20] = 8'h80;
        mem[16'h50] = 8'h34;
        mem[16'h51] = 8'hB2;
        mem[16'h62] = 8'h77;
        mem[16'h42] = 8'hEE;
        mem[16'h43] = 8'hEE;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check(!req_ready, "rst_req_ready", 32'(req_ready), 32'h0);
        check(!rsp_valid, "rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check(!ram_we, "rst_ram_we", 32'(ram_we), 32'h0);
        check(ram_addr == 16'h0, "rst_ram_addr", 32'(ram_addr), 32'h0);
        check(ram_wdata == 8'h0, "rst_ram_wdata", 32'(ram_wdata), 32'h0);
        check(rsp_rdata == 32'h0, "rst_rsp_rdata", rsp_rdata, 32'h0);
        check(!rsp_err, "rst_rsp_err", 32'(rsp_err), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check(req_ready, "idle_ready", 32'(req_ready), 32'h1);

        // Word store
        @(posedge clk);
        #1 we_cnt = 0;
        issue(1, 2'b10, 0, 16'h0010, 32'hA1B2C3D4, 1, 32'h0, 0, 5);
        drain();
        check(mem[16'h10] == 8'hD4, "st_w_b0", 32'(mem[16'h10]), 32'hD4);
        check(mem[16'h11] == 8'hC3, "st_w_b1", 32'(mem[16'h11]), 32'hC3);
        check(mem[16'h12] == 8'hB2, "st_w_b2", 32'(mem[16'h12]), 32'hB2);
        check(mem[16'h13] == 8'hA1, "st_w_b3", 32'(mem[16'h13]), 32'hA1);
        check(we_cnt == 4, "st_w_we_cycles", we_cnt, 32'd4);

        // Loads of all sizes, plus a half store
        issue(0, 2'b00, 1, 16'h0020, 0, 1, 32'hFFFFFF80, 0, 2);
        issue(0, 2'b00, 0, 16'h0020, 0, 1, 32'h00000080, 0, 2);
        issue(0, 2'b01, 1, 16'h0050, 0, 1, 32'hFFFFB234, 0, 3);
        issue(0, 2'b01, 0, 16'h0050, 0, 1, 32'h0000B234, 0, 3);
        issue(0, 2'b10, 1, 16'h0010, 0, 1, 32'hA1B2C3D4, 0, 5);
        issue(1, 2'b01, 0, 16'h0060, 32'hDEADBEEF, 1, 32'h0, 0, 3);
        drain();
        check(mem[16'h60] == 8'hEF, "st_h_b0", 32'(mem[16'h60]), 32'hEF);
        check(mem[16'h61] == 8'hBE, "st_h_b1", 32'(mem[16'h61]), 32'hBE);
        check(mem[16'h62] == 8'h77, "st_h_b2", 32'(mem[16'h62]), 32'h77);

        // Error requests: no RAM cycle, immediate response
        @(posedge clk);
        #1 wc = we_cnt;
        issue(0, 2'b01, 0, 16'h0021, 0, 1, 32'h0, 1, 1);
        issue(0, 2'b11, 0, 16'h0030, 0, 1, 32'h0, 1, 1);
        issue(1, 2'b10, 0, 16'h0012, 32'hFFFFFFFF, 1, 32'h0, 1, 1);
        drain();
        check(we_cnt == wc, "err_no_we", we_cnt, wc);
        check(mem[16'h12] == 8'hB2, "err_no_write", 32'(mem[16'h12]), 32'hB2);

        // Response held off for several cycles
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        issue(0, 2'b00, 0, 16'h0020, 0, 1, 32'h00000080, 0, 2);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(rsp_valid, "hold_valid_seen", 32'(rsp_valid), 32'h1);
        wc = we_cnt;
        @(posedge clk);
        #1;
        req_we = 1'b1;
        req_size = 2'b00;
        req_addr = 16'h0070;
        req_wdata = 32'h00000055;
        req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check(rsp_valid, "hold_valid", 32'(rsp_valid), 32'h1);
            check(rsp_rdata == 32'h80, "hold_rdata", rsp_rdata, 32'h80);
            check(!req_ready, "hold_req_ready", 32'(req_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();
        repeat (2) @(negedge clk);
        check(we_cnt == wc, "hold_no_accept_we", we_cnt, wc);
        check(mem[16'h70] == 8'h00, "hold_no_accept_mem",
              32'(mem[16'h70]), 32'h0);

        // Reset in the middle of a word store
        @(posedge clk);
        #1 we_cnt = 0;
        issue(1, 2'b10, 0, 16'h0040, 32'h11223344, 0, 32'h0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check(!ram_we, "abort_we_low", 32'(ram_we), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check(ram_addr == 16'h0, "abort_addr_zero", 32'(ram_addr), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check(req_ready, "abort_ready", 32'(req_ready), 32'h1);
        repeat (4) @(negedge clk);
        check(we_cnt == 2, "abort_we_cycles", we_cnt, 32'd2);
        check(mem[16'h40] == 8'h44, "abort_b0", 32'(mem[16'h40]), 32'h44);
        check(mem[16'h41] == 8'h33, "abort_b1", 32'(mem[16'h41]), 32'h33);
        check(mem[16'h42] == 8'hEE, "abort_b2", 32'(mem[16'h42]), 32'hEE);
        check(mem[16'h43] == 8'hEE, "abort_b3", 32'(mem[16'h43]), 32'hEE);

        // Back-to-back requests with the consumer always ready
        issue(0, 2'b00, 1, 16'h0020, 0, 1, 32'hFFFFFF80, 0, 2);
        issue(0, 2'b00, 0, 16'h0020, 0, 1, 32'h00000080, 0, 2);
        check(last_acc == hs_edge + 1, "b2b_accept_edge", last_acc, hs_edge + 1);
        drain();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lsu_byte_seq.md
LSU_BYTE_SEQ -- requirements
Module: lsu_byte_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, meaning the byte-address width of the RAM port and request address.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the RAM data width; only 8 is supported.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port i_req_valid, input, 1, which signals that a load/store request is present.
REQ-006 SHALL have port o_req_ready, output, 1, which signals that the block can accept a request.
REQ-007 SHALL have port i_req_we, input, 1, where 1 = store and 0 = load.
REQ-008 SHALL have port i_req_size, input, 2, encoded as 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port i_req_signed, input, 1, which selects sign-extension of load data (0 selects zero-extension).
REQ-010 SHALL have port i_req_addr, input, ADDR_WIDTH, the byte address.
REQ-011 SHALL have port i_req_wdata, input, 32, the store data, taken least-significant-bits first.
REQ-012 SHALL have port o_rsp_valid, output, 1, which signals that a response is present.
REQ-013 SHALL have port i_rsp_ready, input, 1, which signals that the consumer accepts the response.
REQ-014 SHALL have port o_rsp_rdata, output, 32, the extended load data.
REQ-015 SHALL have port o_rsp_err, output, 1, which flags a misaligned or illegal-size request.
REQ-016 SHALL have port o_ram_we, output, 1, the RAM write enable.
REQ-017 SHALL have port o_ram_addr, output, ADDR_WIDTH, the RAM address.
REQ-018 SHALL have port o_ram_wdata, output, 8, the RAM write byte.
REQ-019 SHALL have port i_ram_rdata, input, 8, the RAM read byte, combinationally valid for the current o_ram_addr.

Function
REQ-020 SHALL implement FSM states IDLE, XFER and RESP, with o_req_ready = 1 only in IDLE.
REQ-021 SHALL accept a request on a cycle with i_req_valid && o_req_ready, latching we, size, signed, addr and wdata.
REQ-022 SHALL set the access length N to 1, 2 or 4 for size 00, 01 or 10 respectively.
REQ-023 SHALL treat half with addr[0]=1, word with addr[1:0]!=0, or size 11 as an error: IDLE goes directly to RESP with no RAM cycle, o_rsp_err=1 and o_rsp_rdata=0.
REQ-024 SHALL, on a legal request, go IDLE to XFER with byte counter k=0.
REQ-025 SHALL, for XFER cycle k, drive o_ram_addr = latched addr + k (little-endian), with k running 0..N-1, one byte per cycle.
REQ-026 SHALL, for a store in XFER, drive o_ram_we=1 and o_ram_wdata = wdata[8k+7:8k].
REQ-027 SHALL, for a load in XFER, drive o_ram_we=0 and capture i_ram_rdata into byte lane k at the clock edge ending that cycle.
REQ-028 SHALL move XFER to RESP on the edge ending cycle k=N-1.
REQ-029 SHALL make the legal-request latency exactly N+1 cycles from the acceptance edge to the first o_rsp_valid cycle.
REQ-030 SHALL, in RESP, hold o_rsp_valid=1 with stable o_rsp_rdata and o_rsp_err until i_rsp_ready=1, then go to IDLE on that edge.
REQ-031 SHALL, for a load response, sign-extend from bit 8N-1 when signed=1 and zero-extend otherwise; a store response SHALL carry o_rsp_rdata=0 and o_rsp_err=0.
REQ-032 SHALL drive o_ram_we=0, o_ram_wdata=0 and o_ram_addr = last latched address outside XFER.
REQ-033 SHALL drive o_rsp_valid=0 outside RESP, with o_rsp_rdata/o_rsp_err don't-care there.
REQ-034 SHALL ignore i_req_valid outside IDLE, since no request is accepted there.
REQ-035 SHALL never make an aligned access wrap past 2**ADDR_WIDTH-1, and no wrap handling SHALL be added.

Reset
REQ-036 SHALL, on any edge with i_rst_n=0, force state to IDLE, k=0, all latched fields to 0 and load data to 0.
REQ-037 SHALL drive o_req_ready=0 and o_rsp_valid=0 while i_rst_n=0.
REQ-038 SHALL leave all other outputs at 0 from the first edge with i_rst_n=0.
REQ-039 SHALL, on reset during XFER, abort the access: o_ram_we=0 from the reset edge on, bytes already written remain in RAM, and no response is issued.

Verification
REQ-040 SHALL verify: word store addr 0x0010, wdata 0xA1B2C3D4 -> RAM[0x10..0x13] = D4, C3, B2, A1; o_ram_we high 4 cycles; o_rsp_valid in cycle 5, err=0.
REQ-041 SHALL verify: RAM[0x20]=0x80, byte load addr 0x0020 with signed=1 -> rdata 0xFFFFFF80; with signed=0 -> 0x00000080; latency 2.
REQ-042 SHALL verify: half load addr 0x0021 -> no o_ram_we or address activity, o_rsp_valid next cycle, err=1, rdata 0; size 11 -> err=1.
REQ-043 SHALL verify: i_rsp_ready held 0 for 3 cycles in RESP -> o_rsp_valid and rdata stable, o_req_ready=0, and a new i_req_valid is not accepted.
REQ-044 SHALL verify: reset asserted after 2 bytes of a word store to 0x0040 (0x11223344) -> RAM[0x40]=44, RAM[0x41]=33, RAM[0x42..0x43] unchanged, no o_rsp_valid, o_req_ready=1 after release.
REQ-045 SHALL verify: back-to-back requests with i_rsp_ready=1 -> the next request is accepted one cycle after the response handshake.
